mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (instruction/data) arbiter onto a single backing-memory port
module mem_port_arbiter #(
  parameter bit D_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_a,
  input  logic [31:0] address_a,
  output logic        resp_a,
  output logic [31:0] rdata_a,
  input  logic        read_b,
  input  logic        write,
  input  logic [3:0]  wmask,
  input  logic [31:0] address_b,
  input  logic [31:0] wdata,
  output logic        resp_b,
  output logic [31:0] rdata_b,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_wmask,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_A = 3'd1;
  localparam logic [2:0] BUSY_B = 3'd2;
  localparam logic [2:0] DONE_A = 3'd3;
  localparam logic [2:0] DONE_B = 3'd4;

  logic [2:0]  state, state_nxt;
  logic        last_b;        // 1 when port B received the most recent grant
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;
  logic        lat_write;
  logic        pend_b;
  logic        grant_a, grant_b;
  logic        busy;

  assign pend_b = read_b | write;
  assign busy   = (state == BUSY_A) || (state == BUSY_B);

  // Grant selection in IDLE: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    grant_a = read_a && (!pend_b || last_b);
    grant_b = pend_b && (!read_a || !last_b);
  end

  // Next-state logic; BUSY waits indefinitely on pmem_resp, DONE always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_a)      state_nxt = BUSY_A;
        else if (grant_b) state_nxt = BUSY_B;
      end
      BUSY_A:  if (pmem_resp) state_nxt = DONE_A;
      BUSY_B:  if (pmem_resp) state_nxt = DONE_B;
      DONE_A:  state_nxt = IDLE;
      DONE_B:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latching on grant, and read-data capture on memory completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_b    <= ~D_PRIORITY;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_wmask <= 4'h0;
      lat_write <= 1'b0;
      rdata_a   <= 32'h0;
      rdata_b   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (grant_a) begin
          lat_addr  <= address_a;
          lat_wdata <= 32'h0;
          lat_wmask <= 4'h0;
          lat_write <= 1'b0;
          last_b    <= 1'b0;
        end else if (grant_b) begin
          // read_b together with write is a write
          lat_addr  <= address_b;
          lat_wdata <= wdata;
          lat_wmask <= write ? wmask : 4'h0;
          lat_write <= write;
          last_b    <= 1'b1;
        end
      end
      if (state == BUSY_A && pmem_resp) rdata_a <= pmem_rdata;
      if (state == BUSY_B && pmem_resp && !lat_write) rdata_b <= pmem_rdata;
    end
  end

  // Memory-side outputs are live only while a transaction is in flight
  always_comb begin
    pmem_read    = busy && !lat_write;
    pmem_write   = busy && lat_write;
    pmem_address = busy ? lat_addr : 32'h0;
    pmem_wdata   = busy ? lat_wdata : 32'h0;
    pmem_wmask   = (busy && lat_write) ? lat_wmask : 4'h0;
    resp_a       = (state == DONE_A);
    resp_b       = (state == DONE_B);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - table-driven and directed-sequence bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        read_b;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] address_b;
  logic [31:0] wdata;
  logic        resp_b;
  logic [31:0] rdata_b;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [31:0] pmem_wdata;
  logic [3:0]  pmem_wmask;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.D_PRIORITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
    .read_b(read_b), .write(write), .wmask(wmask), .address_b(address_b),
    .wdata(wdata), .resp_b(resp_b), .rdata_b(rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_wmask(pmem_wmask),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ra, rb, wr, pr;
    logic [31:0] prd;
    logic        e_ra, e_rb, e_pr, e_pw;
    logic [31:0] e_addr;
    logic [3:0]  e_wm;
    logic [31:0] e_da, e_db;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read_a = 1'b0; read_b = 1'b0; write = 1'b0; pmem_resp = 1'b0; pmem_rdata = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    address_a = 32'h60; address_b = 32'h104; wdata = 32'hDEADBEEF; wmask = 4'h3;

    // A-only read, spurious pmem_resp in IDLE, then a B write with five wait cycles
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,  4'h0,32'h0, 32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b1,32'h13,       1'b0,1'b0,1'b1,1'b0,32'h60, 4'h0,32'h0, 32'h0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0,32'h0,  4'h0,32'h13,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b1,32'h55,       1'b0,1'b0,1'b0,1'b0,32'h0,  4'h0,32'h13,32'h0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,  4'h0,32'h13,32'h0};
    tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,  4'h0,32'h13,32'h0};
    for (int k = 6; k <= 10; k++)
      tbl[k] = '{1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0,1'b0,1'b0,1'b1,32'h104,4'h3,32'h13,32'h0};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,32'h77,       1'b0,1'b0,1'b0,1'b1,32'h104,4'h3,32'h13,32'h0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0,32'h0,  4'h0,32'h13,32'h0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,32'h0,  4'h0,32'h13,32'h0};

    #23;
    chk("reset resp_a", {31'h0, resp_a}, 32'h0);
    chk("reset resp_b", {31'h0, resp_b}, 32'h0);
    chk("reset pmem_read", {31'h0, pmem_read}, 32'h0);
    chk("reset pmem_write", {31'h0, pmem_write}, 32'h0);
    chk("reset pmem_address", pmem_address, 32'h0);
    chk("reset rdata_a", rdata_a, 32'h0);
    chk("reset rdata_b", rdata_b, 32'h0);
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      read_a = tbl[i].ra; read_b = tbl[i].rb; write = tbl[i].wr;
      pmem_resp = tbl[i].pr; pmem_rdata = tbl[i].prd;
      @(negedge clk);
      chk($sformatf("v%0d resp_a", i), {31'h0, resp_a}, {31'h0, tbl[i].e_ra});
      chk($sformatf("v%0d resp_b", i), {31'h0, resp_b}, {31'h0, tbl[i].e_rb});
      chk($sformatf("v%0d pmem_read", i), {31'h0, pmem_read}, {31'h0, tbl[i].e_pr});
      chk($sformatf("v%0d pmem_write", i), {31'h0, pmem_write}, {31'h0, tbl[i].e_pw});
      if (tbl[i].e_pr || tbl[i].e_pw)
        chk($sformatf("v%0d pmem_address", i), pmem_address, tbl[i].e_addr);
      chk($sformatf("v%0d pmem_wmask", i), {28'h0, pmem_wmask}, {28'h0, tbl[i].e_wm});
      if (tbl[i].e_pw)
        chk($sformatf("v%0d pmem_wdata", i), pmem_wdata, 32'hDEADBEEF);
      chk($sformatf("v%0d rdata_a", i), rdata_a, tbl[i].e_da);
      chk($sformatf("v%0d rdata_b", i), rdata_b, tbl[i].e_db);
      cyc();
    end

    // read_b and write together behave as a write
    read_b = 1'b1; write = 1'b1;
    cyc();
    pmem_resp = 1'b1; pmem_rdata = 32'h99;
    @(negedge clk);
    chk("rw pmem_write", {31'h0, pmem_write}, 32'h1);
    chk("rw pmem_read", {31'h0, pmem_read}, 32'h0);
    chk("rw pmem_wmask", {28'h0, pmem_wmask}, 32'h3);
    cyc();
    idle_inputs();
    @(negedge clk);
    chk("rw resp_b", {31'h0, resp_b}, 32'h1);
    chk("rw rdata_b unchanged", rdata_b, 32'h0);
    cyc();

    // Reset while BUSY_A abandons the read silently
    read_a = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst busy pmem_read", {31'h0, pmem_read}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst async pmem_read", {31'h0, pmem_read}, 32'h0);
    chk("rst async pmem_address", pmem_address, 32'h0);
    chk("rst async rdata_a", rdata_a, 32'h0);
    read_a = 1'b0;
    pmem_resp = 1'b1;
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("rst no resp_a c%0d", k), {31'h0, resp_a}, 32'h0);
      chk($sformatf("rst idle pmem_read c%0d", k), {31'h0, pmem_read}, 32'h0);
    end
    cyc();

    // Tie after reset: B first, then A, then B
    read_a = 1'b1; read_b = 1'b1; write = 1'b0; pmem_resp = 1'b1; pmem_rdata = 32'hCAFEF00D;
    cyc();
    @(negedge clk);
    chk("tie1 pmem_read", {31'h0, pmem_read}, 32'h1);
    chk("tie1 addr B", pmem_address, 32'h104);
    cyc();
    pmem_rdata = 32'h12345678;
    @(negedge clk);
    chk("tie1 resp_b", {31'h0, resp_b}, 32'h1);
    chk("tie1 rdata_b", rdata_b, 32'hCAFEF00D);
    cyc(); cyc();
    @(negedge clk);
    chk("tie2 addr A", pmem_address, 32'h60);
    cyc();
    @(negedge clk);
    chk("tie2 resp_a", {31'h0, resp_a}, 32'h1);
    chk("tie2 rdata_a", rdata_a, 32'h12345678);
    cyc(); cyc();
    @(negedge clk);
    chk("tie3 addr B", pmem_address, 32'h104);
    chk("tie3 pmem_read", {31'h0, pmem_read}, 32'h1);
    idle_inputs();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
